// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/issue sequencer. Requests an instruction at PC, latches
// the response, presents it for issue, then advances PC sequentially or by
// branch/jump. A fetch that waits too long for IAck parks the block in HALTED
// with a sticky Timeout flag until reset.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          WAIT_LIMIT = 15
) (
    input  logic        C,
    input  logic        CLRbar,
    input  logic        Start,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IAck,
    input  logic [31:0] IData,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [31:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic        Halt,
    output logic [31:0] PC,
    output logic        Busy,
    output logic        Timeout
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [31:0]     pc, pc_next;
    logic [31:0]     instr, instr_next;
    logic [CW-1:0]   wait_cnt, wait_cnt_next;
    logic            timeout, timeout_next;
    logic [31:0]     pc_plus4;

    // State and datapath registers; reset is asynchronous so outputs drop at once.
    always_ff @(posedge C or negedge CLRbar) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values regardless of statement order.
        if (!CLRbar) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            instr    <= instr_next;
            wait_cnt <= wait_cnt_next;
            timeout  <= timeout_next;
        end
    end

    assign pc_plus4 = pc + 32'd4;

    // Next-state and register-update decisions for each sequencer state.
    always_comb begin
        // NOTE: every signal written here gets a hold/default value first so no
        // path leaves it unassigned, which would infer a latch.
        state_next    = state;
        pc_next       = pc;
        instr_next    = instr;
        wait_cnt_next = wait_cnt;
        timeout_next  = timeout;

        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_next    = FETCH;
                    wait_cnt_next = '0;
                end
            end
            FETCH: begin
                if (IAck) begin
                    instr_next = IData;
                    state_next = ISSUE;
                end else begin
                    wait_cnt_next = wait_cnt + 1'b1;
                    // This cycle is the WAIT_LIMIT-th one without a response.
                    if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
                        timeout_next = 1'b1;
                        state_next   = HALTED;
                    end
                end
            end
            ISSUE: begin
                if (Stall) begin
                    state_next = ISSUE;
                end else if (Halt) begin
                    state_next = HALTED;
                end else begin
                    if (Jump)
                        pc_next = {pc_plus4[31:28], JumpTarget, 2'b00};
                    else if (Branch)
                        pc_next = pc_plus4 + (BranchOffset << 2);
                    else
                        pc_next = pc_plus4;
                    state_next    = FETCH;
                    wait_cnt_next = '0;
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registered state so reset clears them immediately.
    assign IReq       = (state == FETCH);
    assign InstrValid = (state == ISSUE);
    assign Busy       = (state == FETCH) || (state == ISSUE);
    assign IAddr      = pc;
    assign PC         = pc;
    assign Instr      = instr;
    assign Timeout    = timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: fetch/issue flow, branch/jump arithmetic,
// stall/halt priority, fetch timeout, PC wraparound and asynchronous reset.
module tb_pc_sequencer;

    logic        C = 1'b0;
    logic        CLRbar;
    logic        Start, IAck, Stall, Branch, Jump, Halt;
    logic [31:0] IData, BranchOffset;
    logic [25:0] JumpTarget;

    logic        ireq0, ivalid0, busy0, tout0;
    logic [31:0] iaddr0, instr0, pc0;
    logic        ireq1, ivalid1, busy1, tout1;
    logic [31:0] iaddr1, instr1, pc1;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.RESET_PC(32'h0000_0000), .WAIT_LIMIT(15)) u0 (
        .C(C), .CLRbar(CLRbar), .Start(Start), .IReq(ireq0), .IAddr(iaddr0),
        .IAck(IAck), .IData(IData), .Instr(instr0), .InstrValid(ivalid0),
        .Stall(Stall), .Branch(Branch), .BranchOffset(BranchOffset), .Jump(Jump),
        .JumpTarget(JumpTarget), .Halt(Halt), .PC(pc0), .Busy(busy0), .Timeout(tout0)
    );

    pc_sequencer #(.RESET_PC(32'hFFFF_FFFC), .WAIT_LIMIT(15)) u1 (
        .C(C), .CLRbar(CLRbar), .Start(Start), .IReq(ireq1), .IAddr(iaddr1),
        .IAck(IAck), .IData(IData), .Instr(instr1), .InstrValid(ivalid1),
        .Stall(Stall), .Branch(Branch), .BranchOffset(BranchOffset), .Jump(Jump),
        .JumpTarget(JumpTarget), .Halt(Halt), .PC(pc1), .Busy(busy1), .Timeout(tout1)
    );

    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge C);
        #1;
    endtask

    // From FETCH: return the word this cycle, leaving the block in ISSUE.
    task automatic ack_word(input logic [31:0] w);
        IAck  = 1'b1;
        IData = w;
        step();
        IAck  = 1'b0;
    endtask

    // Pulse reset between clock edges and return just after the next edge.
    task automatic pulse_reset();
        @(negedge C);
        CLRbar = 1'b0;
        #2;
        CLRbar = 1'b1;
        step();
    endtask

    initial begin
        CLRbar = 1'b0; Start = 0; IAck = 0; Stall = 0; Branch = 0; Jump = 0; Halt = 0;
        IData = '0; BranchOffset = '0; JumpTarget = '0;
        #12;
        check("rst_ireq",    {31'd0, ireq0},   32'd0);
        check("rst_valid",   {31'd0, ivalid0}, 32'd0);
        check("rst_busy",    {31'd0, busy0},   32'd0);
        check("rst_tout",    {31'd0, tout0},   32'd0);
        check("rst_pc",      pc0,              32'h0000_0000);
        check("rst_instr",   instr0,           32'h0000_0000);
        check("rst_pc_hi",   pc1,              32'hFFFF_FFFC);

        // Basic fetch: Start, two cycles with no response, then IAck.
        @(negedge C); CLRbar = 1'b1;
        step();
        check("idle_ignores", {31'd0, ireq0}, 32'd0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("fetch_ireq",  {31'd0, ireq0}, 32'd1);
        check("fetch_iaddr", iaddr0,         32'h0000_0000);
        check("fetch_busy",  {31'd0, busy0}, 32'd1);
        check("fetch_iaddr_hi", iaddr1,      32'hFFFF_FFFC);
        step();
        step();
        check("fetch_wait_ireq", {31'd0, ireq0}, 32'd1);
        ack_word(32'h2008_0005);
        check("issue_instr", instr0,           32'h2008_0005);
        check("issue_valid", {31'd0, ivalid0}, 32'd1);
        check("issue_ireq",  {31'd0, ireq0},   32'd0);
        step();
        check("seq_pc",      pc0,              32'h0000_0004);
        check("seq_ireq",    {31'd0, ireq0},   32'd1);
        check("seq_valid",   {31'd0, ivalid0}, 32'd0);
        check("wrap_pc",     pc1,              32'h0000_0000);

        // Advance sequentially to PC=0x10 and take a backward branch.
        for (int i = 0; i < 3; i++) begin
            ack_word(32'h1000_0000 + i);
            step();
        end
        check("seq_pc_10", pc0, 32'h0000_0010);
        ack_word(32'hAAAA_0001);
        Branch = 1'b1; BranchOffset = 32'hFFFF_FFFC;
        step();
        Branch = 1'b0;
        check("branch_pc",   pc0,            32'h0000_0004);
        check("branch_ireq", {31'd0, ireq0}, 32'd1);

        // Back to 0x10; Jump outranks Branch.
        for (int i = 0; i < 3; i++) begin
            ack_word(32'h2000_0000 + i);
            step();
        end
        ack_word(32'hBBBB_0002);
        Jump = 1'b1; Branch = 1'b1; JumpTarget = 26'h000_0040;
        step();
        Jump = 1'b0; Branch = 1'b0;
        check("jump_pc", pc0, 32'h0000_0100);

        // Stall holds the instruction and PC; Halt waits until Stall drops.
        ack_word(32'hCCCC_0003);
        Stall = 1'b1; Halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_valid", {31'd0, ivalid0}, 32'd1);
            check("stall_pc",    pc0,              32'h0000_0100);
            check("stall_instr", instr0,           32'hCCCC_0003);
        end
        Stall = 1'b0;
        step();
        Halt = 1'b0;
        check("halt_valid", {31'd0, ivalid0}, 32'd0);
        check("halt_busy",  {31'd0, busy0},   32'd0);
        check("halt_ireq",  {31'd0, ireq0},   32'd0);
        check("halt_pc",    pc0,              32'h0000_0100);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("halt_ignores_start", {31'd0, busy0}, 32'd0);
        check("halt_no_tout",       {31'd0, tout0}, 32'd0);

        // Fetch timeout after 15 cycles without IAck.
        pulse_reset();
        check("rst2_pc",   pc0,            32'h0000_0000);
        check("rst2_busy", {31'd0, busy0}, 32'd0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("to_still_fetch", {31'd0, ireq0}, 32'd1);
        check("to_not_yet",     {31'd0, tout0}, 32'd0);
        step();
        check("to_flag", {31'd0, tout0}, 32'd1);
        check("to_ireq", {31'd0, ireq0}, 32'd0);
        check("to_busy", {31'd0, busy0}, 32'd0);
        check("to_pc",   pc0,            32'h0000_0000);
        IAck = 1'b1;
        Start = 1'b1;
        step();
        step();
        IAck = 1'b0;
        Start = 1'b0;
        check("to_sticky", {31'd0, tout0}, 32'd1);
        check("to_stays",  {31'd0, busy0}, 32'd0);

        // Reset clears Timeout; a reset between edges mid-FETCH drops IReq at once.
        pulse_reset();
        check("rst3_tout", {31'd0, tout0}, 32'd0);
        Start = 1'b1;
        step();
        Start = 1'b0;
        check("pre_async_ireq", {31'd0, ireq0}, 32'd1);
        #2;
        CLRbar = 1'b0;
        #1;
        check("async_ireq", {31'd0, ireq0}, 32'd0);
        check("async_pc",   pc0,            32'h0000_0000);
        check("async_pc_hi", pc1,           32'hFFFF_FFFC);
        CLRbar = 1'b1;
        step();
        step();
        check("async_idle", {31'd0, busy0}, 32'd0);

        // Reset mid-ISSUE drops InstrValid and clears Instr immediately.
        Start = 1'b1;
        step();
        Start = 1'b0;
        ack_word(32'hDDDD_0004);
        check("pre_rst_valid", {31'd0, ivalid0}, 32'd1);
        #2;
        CLRbar = 1'b0;
        #1;
        check("rst_issue_valid", {31'd0, ivalid0}, 32'd0);
        check("rst_issue_instr", instr0,           32'h0000_0000);
        CLRbar = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
